// File: rtl/ula_pipe_if.sv
// Request/result bundle for ula_pipe: valid/ready request side and valid/ready result side.
interface ula_pipe_if #(
   parameter int WIDTH = 16
);
   logic                 i_valid;
   logic                 o_ready;
   logic [3:0]           i_op_selector;
   logic [WIDTH-1:0]     i_data_a;
   logic [WIDTH-1:0]     i_data_b;
   logic                 o_data_valid;
   logic                 i_data_ready;
   logic [2*WIDTH-1:0]   o_data_result;
   logic                 o_data_carryout;
   logic                 o_data_error;

   modport master (
      output i_valid, i_op_selector, i_data_a, i_data_b, i_data_ready,
      input  o_ready, o_data_valid, o_data_result, o_data_carryout, o_data_error
   );

   modport slave (
      input  i_valid, i_op_selector, i_data_a, i_data_b, i_data_ready,
      output o_ready, o_data_valid, o_data_result, o_data_carryout, o_data_error
   );
endinterface

// File: rtl/ula_pipe.sv
// Handshaked ALU: single-cycle ops plus a WIDTH-cycle restoring divider, result held under backpressure.
//   state   | meaning
//   IDLE    | ready for a request when the output slot is free or draining
//   DIV_RUN | restoring divider producing one quotient bit per clock
module ula_pipe #(
   parameter int WIDTH = 16
) (
   input logic       clk,
   input logic       rst,
   ula_pipe_if.slave bus
);
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_MUL = 4'd3;
   localparam logic [3:0] OP_DIV = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_XOR = 4'd7;
   localparam logic [3:0] OP_REV = 4'd8;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, DIV_RUN} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic                 valid_q, valid_d, carry_q, carry_d, err_q, err_d;
   logic [2*WIDTH-1:0]   res_q, res_d;

   logic                 ready, accept;
   logic [WIDTH:0]       sum, trial, diff;
   logic [2*WIDTH-1:0]   prod, alu_res;
   logic [WIDTH-1:0]     rev_a, rem_step, quo_step;
   logic                 alu_carry, alu_err;

   always_comb begin
      sum       = {1'b0, bus.i_data_a} + {1'b0, bus.i_data_b};
      prod      = {{WIDTH{1'b0}}, bus.i_data_a} * {{WIDTH{1'b0}}, bus.i_data_b};
      rev_a     = '0;
      for (int i = 0; i < WIDTH; i++) rev_a[i] = bus.i_data_a[WIDTH-1-i];
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_err   = 1'b0;
      case (bus.i_op_selector)
         OP_ADD: begin
            alu_res   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
            alu_carry = sum[WIDTH];
         end
         OP_SUB: begin
            alu_res   = {{WIDTH{1'b0}}, bus.i_data_a - bus.i_data_b};
            alu_carry = bus.i_data_a < bus.i_data_b;
         end
         OP_MUL: alu_res = prod;
         // Only reached here for a zero divisor; real divides go through DIV_RUN.
         OP_DIV: begin
            alu_res = {bus.i_data_a, {WIDTH{1'b1}}};
            alu_err = 1'b1;
         end
         OP_AND: alu_res = {{WIDTH{1'b0}}, bus.i_data_a & bus.i_data_b};
         OP_OR:  alu_res = {{WIDTH{1'b0}}, bus.i_data_a | bus.i_data_b};
         OP_XOR: alu_res = {{WIDTH{1'b0}}, bus.i_data_a ^ bus.i_data_b};
         OP_REV: alu_res = {{WIDTH{1'b0}}, rev_a};
         default: alu_err = 1'b1;
      endcase
   end

   always_comb begin
      trial    = {rem_q, quo_q[WIDTH-1]};
      diff     = trial - {1'b0, dvs_q};
      rem_step = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      valid_d = valid_q;
      res_d   = res_q;
      carry_d = carry_q;
      err_d   = err_q;
      ready   = rst && (state_q == IDLE) && (!valid_q || bus.i_data_ready);
      accept  = bus.i_valid && ready;
      if (valid_q && bus.i_data_ready) valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.i_op_selector == OP_DIV && bus.i_data_b != '0) begin
                  state_d = DIV_RUN;
                  cnt_d   = CW'(WIDTH);
                  rem_d   = '0;
                  quo_d   = bus.i_data_a;
                  dvs_d   = bus.i_data_b;
               end else begin
                  valid_d = 1'b1;
                  res_d   = alu_res;
                  carry_d = alu_carry;
                  err_d   = alu_err;
               end
            end
         end
         DIV_RUN: begin
            if (cnt_q != CW'(1)) begin
               cnt_d = cnt_q - CW'(1);
               rem_d = rem_step;
               quo_d = quo_step;
            // Last bit waits for the output slot so a held result is never overwritten.
            end else if (!valid_q || bus.i_data_ready) begin
               cnt_d   = '0;
               rem_d   = rem_step;
               quo_d   = quo_step;
               valid_d = 1'b1;
               res_d   = {rem_step, quo_step};
               carry_d = 1'b0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         valid_q <= 1'b0;
         res_q   <= '0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         valid_q <= valid_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         err_q   <= err_d;
      end
   end

   assign bus.o_ready         = ready;
   assign bus.o_data_valid    = valid_q;
   assign bus.o_data_result   = res_q;
   assign bus.o_data_carryout = carry_q;
   assign bus.o_data_error    = err_q;
endmodule

// File: doc/ula_pipe.md
Name: ula_pipe

Overview:
- Parametrised successor to the single-cycle ALU. It adds WIDTH-generic operands, a valid/ready handshake on both input and output, and a multi-cycle restoring divider.
- Output is held under backpressure; divide-by-zero and illegal opcodes are reported through an error flag.
- Sits between the sequence-driven stimulus interface and the result consumer in the ALU datapath.
- Reuses the existing 4-bit op encoding: 0 UNUSED, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 AND, 6 OR, 7 XOR, 8 REV.

Parameters:
WIDTH, 16, operand width in bits; legal range 4..32; result width is 2*WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset (low = reset asserted).
i_valid  input  1  request valid.
o_ready  output  1  block can accept a request this cycle.
i_op_selector  input  4  operation code.
i_data_a  input  WIDTH  operand A.
i_data_b  input  WIDTH  operand B.
o_data_valid  output  1  result valid.
i_data_ready  input  1  consumer accepts result this cycle.
o_data_result  output  2*WIDTH  result.
o_data_carryout  output  1  carry/borrow flag.
o_data_error  output  1  div-by-zero or illegal opcode.

Behaviour:
- Reset (rst low, async):
  - o_data_valid, o_data_result, o_data_carryout and o_data_error = 0.
  - FSM = IDLE; divider counter and registers cleared.
  - o_ready forced 0 while rst is low.
- Accept: i_valid && o_ready at a rising edge. Operands and opcode are captured on that edge.
- o_ready = (state==IDLE) && (!o_data_valid || i_data_ready). This is combinational and allows back-to-back issue when the output is drained in the same cycle.
- FSM states: IDLE, DIV_RUN.
  - IDLE + accept of non-DIV op: result computed and registered on the accepting edge; o_data_valid=1 from that edge (latency 1 cycle).
  - IDLE + accept of DIV with b!=0: go to DIV_RUN and load counter = WIDTH. One quotient bit is produced per edge. On the edge where the counter reaches 0, register the result, set o_data_valid=1 and return to IDLE. o_data_valid rises WIDTH cycles after the accepting edge.
  - DIV with b==0: handled like a non-DIV op (latency 1), no DIV_RUN.
- Output hold: while o_data_valid && !i_data_ready, o_data_result, o_data_carryout and o_data_error stay stable and o_ready=0.
- Output drain: o_data_valid clears on the edge where i_data_ready=1, unless a new non-DIV result is registered on that same edge, in which case it stays 1 with the new data.
- Arithmetic (upper WIDTH result bits = 0 unless stated):
  - ADD: low WIDTH = (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum.
  - SUB: low WIDTH = (a-b) mod 2^WIDTH; carry = borrow (1 iff a<b).
  - MUL: full unsigned 2*WIDTH product; carry 0.
  - DIV: result = {remainder, quotient}, unsigned; carry 0.
  - DIV with b==0: quotient all ones, remainder = a, error=1.
  - AND/OR/XOR: bitwise on WIDTH bits; carry 0.
  - REV: low WIDTH = bit-reverse of a (bit i = a[WIDTH-1-i]); b ignored; carry 0.
  - UNUSED (0) and codes 9..15: result 0, carry 0, error=1. Still produces a handshake response so the requester never hangs.
- error = 0 for every legal, non-faulting operation.
- Reset mid-operation (including DIV_RUN or a held output): immediate abort. No stale result appears after reset release.
- i_valid while o_ready=0: request is ignored; the requester must hold it.
- Operand inputs may change freely after the accepting edge.

Test Plan:
- ADD a=0xFFFF b=0x0001, i_data_ready=1 -> o_data_valid one cycle after accept, result 0x00000000, carry 1, error 0.
- SUB a=0x0003 b=0x0005 -> result 0x0000FFFE, carry 1. Then MUL a=0xFFFF b=0xFFFF issued back-to-back -> result 0xFFFE0001, carry 0, both with no bubble.
- DIV a=100 b=7 -> o_ready 0 during DIV_RUN; o_data_valid exactly 16 cycles after accept; result 0x0002000E. Then DIV a=0x1234 b=0 -> result 0x1234FFFF, error 1, latency 1.
- Backpressure: ADD 0x0010+0x0020 with i_data_ready=0 for 5 cycles -> result 0x00000030 held stable, o_ready 0, a concurrent i_valid (XOR) not accepted. On i_data_ready=1 the XOR is accepted and its result follows next cycle.
- Illegal opcode 0xA and opcode 0x0 -> result 0, carry 0, error 1, valid after 1 cycle. REV a=0x0001 -> result 0x00008000, error 0.
- Reset mid-DIV: DIV 0xFFFF/0x0003 with rst low for 2 cycles at the 5th DIV_RUN cycle -> all outputs 0 immediately and o_ready 0. After release: no o_data_valid pulse, o_ready 1, and a new AND 0x0F0F&0x00FF returns 0x0000000F.
